// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of a full-page-burst SDRAM controller.
// Commands are issued one at a time; data strobes route combinationally to the owning port.
module sdram_arbiter #(
    parameter int BURST_LEN     = 512,
    parameter int START_TIMEOUT = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic        p0_rw,
    input  logic [14:0] p0_addr,
    output logic        p0_gnt,
    input  logic [15:0] p0_wdata,
    output logic        p0_wdata_req,
    output logic [15:0] p0_rdata,
    output logic        p0_rdata_valid,
    output logic        p0_done,
    input  logic        p1_req,
    input  logic        p1_rw,
    input  logic [14:0] p1_addr,
    output logic        p1_gnt,
    input  logic [15:0] p1_wdata,
    output logic        p1_wdata_req,
    output logic [15:0] p1_rdata,
    output logic        p1_rdata_valid,
    output logic        p1_done,
    input  logic        c_ready,
    output logic        c_rw_en,
    output logic        c_rw,
    output logic [14:0] c_addr,
    output logic [15:0] c_wdata,
    input  logic        c_wdata_req,
    input  logic [15:0] c_rdata,
    input  logic        c_rdata_valid,
    output logic        err
);
    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, BURST, DRAIN} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          rw_q, rw_d;
    logic          last_q, last_d;
    logic          err_q, err_d;
    logic          tmo_hit_q, tmo_hit_d;
    logic [14:0]   addr_q, addr_d;
    logic [9:0]    beat_q, beat_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          data_phase;
    logic          strobe;

    assign data_phase = (state_q == WAIT_START) || (state_q == BURST);
    // Only strobes matching the latched direction advance the burst.
    assign strobe     = rw_q ? c_rdata_valid : c_wdata_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            rw_q      <= 1'b0;
            last_q    <= 1'b1;
            err_q     <= 1'b0;
            tmo_hit_q <= 1'b0;
            addr_q    <= '0;
            beat_q    <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rw_q      <= rw_d;
            last_q    <= last_d;
            err_q     <= err_d;
            tmo_hit_q <= tmo_hit_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rw_d      = rw_q;
        last_d    = last_q;
        err_d     = err_q;
        tmo_hit_d = tmo_hit_q;
        addr_d    = addr_q;
        beat_d    = beat_q;
        tmo_d     = tmo_q;
        c_rw_en   = 1'b0;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        p0_done   = 1'b0;
        p1_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (c_ready && (p0_req || p1_req)) begin
                    owner_d = (p0_req && p1_req) ? ~last_q : p1_req;
                    rw_d    = owner_d ? p1_rw : p0_rw;
                    addr_d  = owner_d ? p1_addr : p0_addr;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                c_rw_en   = 1'b1;
                p0_gnt    = ~owner_q;
                p1_gnt    = owner_q;
                beat_d    = '0;
                tmo_d     = '0;
                tmo_hit_d = 1'b0;
                state_d   = WAIT_START;
            end
            WAIT_START: begin
                if (strobe) begin
                    beat_d  = 10'd1;
                    state_d = (BURST_LEN == 1) ? DRAIN : BURST;
                end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
                    err_d     = 1'b1;
                    tmo_hit_d = 1'b1;
                    state_d   = DRAIN;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            BURST: begin
                if (strobe) begin
                    beat_d = beat_q + 10'd1;
                    if (beat_q == 10'(BURST_LEN - 1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A timed-out burst leaves the pointer alone so the same port retries.
                if (c_ready) begin
                    if (!tmo_hit_q) begin
                        p0_done = ~owner_q;
                        p1_done = owner_q;
                        last_d  = owner_q;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign c_rw           = rw_q;
    assign c_addr         = addr_q;
    assign err            = err_q;
    assign c_wdata        = data_phase ? (owner_q ? p1_wdata : p0_wdata) : 16'h0000;
    assign p0_wdata_req   = c_wdata_req & ~rw_q & data_phase & ~owner_q;
    assign p1_wdata_req   = c_wdata_req & ~rw_q & data_phase & owner_q;
    assign p0_rdata_valid = c_rdata_valid & rw_q & data_phase & ~owner_q;
    assign p1_rdata_valid = c_rdata_valid & rw_q & data_phase & owner_q;
    assign p0_rdata       = c_rdata;
    assign p1_rdata       = c_rdata;
endmodule
